// File: rtl/fe_fb.sv
// Fetch fill buffer: one-line instruction buffer in front of memory.
// Serves hits in one cycle and refills the line on a miss, one request at a time.
module fe_fb #(
  parameter int LINE_BYTES = 16,
  parameter int PADDR_W    = 32,
  parameter int ID_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fe_fb_req_nnn_valid,
  input  logic [ID_W-1:0]         fe_fb_req_nnn_id,
  input  logic [PADDR_W-1:0]      fe_fb_req_nnn_addr,
  output logic                    fb_fe_rsp_nnn_valid,
  output logic [ID_W-1:0]         fb_fe_rsp_nnn_id,
  output logic [PADDR_W-1:0]      fb_fe_rsp_nnn_pc,
  output logic [31:0]             fb_fe_rsp_nnn_instr,
  input  logic                    br_mispred_ex0_valid,
  input  logic                    nuke_rb1_valid,
  output logic                    fb_mem_req_valid,
  output logic [PADDR_W-1:0]      fb_mem_req_addr,
  input  logic                    mem_fb_req_ready,
  input  logic                    mem_fb_rsp_valid,
  input  logic [8*LINE_BYTES-1:0] mem_fb_rsp_data
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int WORD_W = OFF_W - 2;
  localparam int TAG_W  = PADDR_W - OFF_W;

  typedef enum logic [1:0] {FB_IDLE, FB_MEM_REQ, FB_MEM_WAIT, FB_FILL_RSP} fb_state_e;

  fb_state_e              state_q;
  logic                   line_valid_q;
  logic [TAG_W-1:0]       tag_q;
  logic [8*LINE_BYTES-1:0] data_q;
  logic                   drop_q;
  logic [PADDR_W-1:0]     req_addr_q;
  logic [ID_W-1:0]        req_id_q;
  logic                   rsp_valid_q;
  logic [ID_W-1:0]        rsp_id_q;
  logic [PADDR_W-1:0]     rsp_pc_q;
  logic [31:0]            rsp_instr_q;
  logic                   mem_req_valid_q;
  logic [PADDR_W-1:0]     mem_req_addr_q;

  logic                   flush;
  logic                   req_take;
  logic                   req_hit;
  logic [31:0]            hit_instr;
  logic [31:0]            fill_instr;

  function automatic logic [31:0] word_sel(input logic [8*LINE_BYTES-1:0] line,
                                           input logic [WORD_W-1:0] idx);
    word_sel = line[32*idx +: 32];
  endfunction

  always_comb begin
    flush      = br_mispred_ex0_valid | nuke_rb1_valid;
    req_take   = fe_fb_req_nnn_valid & ~flush & (state_q == FB_IDLE);
    req_hit    = line_valid_q & (tag_q == fe_fb_req_nnn_addr[PADDR_W-1:OFF_W]);
    hit_instr  = word_sel(data_q, fe_fb_req_nnn_addr[OFF_W-1:2]);
    fill_instr = word_sel(mem_fb_rsp_data, req_addr_q[OFF_W-1:2]);
  end

  // Response registers default to zero each cycle so idle fields read '0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FB_IDLE;
      line_valid_q    <= 1'b0;
      drop_q          <= 1'b0;
      req_addr_q      <= '0;
      req_id_q        <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_pc_q        <= '0;
      rsp_instr_q     <= 32'h0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_pc_q    <= '0;
      rsp_instr_q <= 32'h0;
      case (state_q)
        FB_IDLE: begin
          drop_q <= 1'b0;
          if (req_take && req_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= fe_fb_req_nnn_id;
            rsp_pc_q    <= fe_fb_req_nnn_addr;
            rsp_instr_q <= hit_instr;
          end else if (req_take) begin
            req_addr_q      <= fe_fb_req_nnn_addr;
            req_id_q        <= fe_fb_req_nnn_id;
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {fe_fb_req_nnn_addr[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state_q         <= FB_MEM_REQ;
          end
        end
        FB_MEM_REQ: begin
          if (flush) drop_q <= 1'b1;
          if (mem_fb_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= FB_MEM_WAIT;
          end
        end
        FB_MEM_WAIT: begin
          if (flush) drop_q <= 1'b1;
          // A flushed fill still lands in the line; only the response is suppressed.
          if (mem_fb_rsp_valid) begin
            data_q       <= mem_fb_rsp_data;
            tag_q        <= req_addr_q[PADDR_W-1:OFF_W];
            line_valid_q <= 1'b1;
            state_q      <= FB_FILL_RSP;
            if (!(drop_q || flush)) begin
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= req_id_q;
              rsp_pc_q    <= req_addr_q;
              rsp_instr_q <= fill_instr;
            end
          end
        end
        FB_FILL_RSP: begin
          drop_q  <= 1'b0;
          state_q <= FB_IDLE;
        end
        default: state_q <= FB_IDLE;
      endcase
    end
  end

  assign fb_fe_rsp_nnn_valid = rsp_valid_q;
  assign fb_fe_rsp_nnn_id    = rsp_id_q;
  assign fb_fe_rsp_nnn_pc    = rsp_pc_q;
  assign fb_fe_rsp_nnn_instr = rsp_instr_q;
  assign fb_mem_req_valid    = mem_req_valid_q;
  assign fb_mem_req_addr     = mem_req_addr_q;

  fe_fb_chk u_chk (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_idle_i   (state_q == FB_IDLE),
    .in_wait_i   (state_q == FB_MEM_WAIT),
    .req_valid_i (fe_fb_req_nnn_valid),
    .rsp_valid_i (mem_fb_rsp_valid)
  );

endmodule

// Protocol checker: flags inputs the fill buffer is allowed to ignore.
module fe_fb_chk (
  input logic clk_i,
  input logic reset_i,
  input logic in_idle_i,
  input logic in_wait_i,
  input logic req_valid_i,
  input logic rsp_valid_i
);

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(req_valid_i && !in_idle_i))
        else $warning("fe_fb: fetch request ignored while a fill is outstanding");
      assert (!(rsp_valid_i && !in_wait_i))
        else $warning("fe_fb: memory response ignored outside FB_MEM_WAIT");
    end
  end

endmodule

// File: tb/tb_fe_fb.sv
// Directed bench for fe_fb: miss/fill, hits, stalled handshake, flushes, reset mid-fill.
module tb_fe_fb;

  localparam int LINE_BYTES = 16;
  localparam int PADDR_W    = 32;
  localparam int ID_W       = 4;

  logic                    clk;
  logic                    reset;
  logic                    req_valid;
  logic [ID_W-1:0]         req_id;
  logic [PADDR_W-1:0]      req_addr;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [PADDR_W-1:0]      rsp_pc;
  logic [31:0]             rsp_instr;
  logic                    br_valid;
  logic                    nuke_valid;
  logic                    mreq_valid;
  logic [PADDR_W-1:0]      mreq_addr;
  logic                    mreq_ready;
  logic                    mrsp_valid;
  logic [8*LINE_BYTES-1:0] mrsp_data;

  int tests_run    = 0;
  int tests_failed = 0;

  fe_fb #(.LINE_BYTES(LINE_BYTES), .PADDR_W(PADDR_W), .ID_W(ID_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fe_fb_req_nnn_valid (req_valid),
    .fe_fb_req_nnn_id    (req_id),
    .fe_fb_req_nnn_addr  (req_addr),
    .fb_fe_rsp_nnn_valid (rsp_valid),
    .fb_fe_rsp_nnn_id    (rsp_id),
    .fb_fe_rsp_nnn_pc    (rsp_pc),
    .fb_fe_rsp_nnn_instr (rsp_instr),
    .br_mispred_ex0_valid(br_valid),
    .nuke_rb1_valid      (nuke_valid),
    .fb_mem_req_valid    (mreq_valid),
    .fb_mem_req_addr     (mreq_addr),
    .mem_fb_req_ready    (mreq_ready),
    .mem_fb_rsp_valid    (mrsp_valid),
    .mem_fb_rsp_data     (mrsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [ID_W-1:0] id, input logic [PADDR_W-1:0] a);
    req_valid = v;
    req_id    = id;
    req_addr  = a;
  endtask

  task automatic test_reset();
    reset = 1'b1; br_valid = 1'b0; nuke_valid = 1'b0; mreq_ready = 1'b0;
    mrsp_valid = 1'b0; mrsp_data = '0; drive_req(1'b0, 4'd0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_pc, rsp_instr} !== '0) begin
      tests_failed++; $display("FAIL reset_rsp got %0b/%h/%h/%h want all 0", rsp_valid, rsp_id, rsp_pc, rsp_instr);
    end
    tests_run++;
    if ({mreq_valid, mreq_addr} !== '0) begin
      tests_failed++; $display("FAIL reset_memreq got %0b/%h want 0/0", mreq_valid, mreq_addr);
    end
  endtask

  task automatic test_miss_fill();
    drive_req(1'b1, 4'd0, 32'h100);
    tick();
    drive_req(1'b0, 4'd0, 32'h0);
    tests_run++;
    if (mreq_valid !== 1'b1 || mreq_addr !== 32'h100) begin
      tests_failed++; $display("FAIL miss_memreq got %0b/%h want 1/00000100", mreq_valid, mreq_addr);
    end
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    tests_run++;
    if (mreq_valid !== 1'b0) begin
      tests_failed++; $display("FAIL miss_memreq_drop got %0b want 0", mreq_valid);
    end
    tick(); tick();
    mrsp_valid = 1'b1;
    mrsp_data  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    tick();
    mrsp_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_pc !== 32'h100 || rsp_instr !== 32'h00000000 || rsp_id !== 4'd0) begin
      tests_failed++; $display("FAIL fill_rsp got %0b/%h/%h/%h want 1/00000100/00000000/0", rsp_valid, rsp_pc, rsp_instr, rsp_id);
    end
    tick();
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_pc, rsp_instr} !== '0) begin
      tests_failed++; $display("FAIL fill_rsp_clear got %0b/%h/%h/%h want all 0", rsp_valid, rsp_id, rsp_pc, rsp_instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222; exp_w[2] = 32'h33333333;
    drive_req(1'b1, 4'd1, 32'h104);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_instr !== exp_w[i] || rsp_pc !== 32'h104 + 32'(4*i)
          || rsp_id !== 4'(i+1) || mreq_valid !== 1'b0) begin
        tests_failed++; $display("FAIL hit_b2b[%0d] got %0b/%h/%h/%h mreq %0b want 1/%h/%h/%h mreq 0",
          i, rsp_valid, rsp_pc, rsp_instr, rsp_id, mreq_valid, 32'h104 + 32'(4*i), exp_w[i], 4'(i+1));
      end
      if (i < 2) drive_req(1'b1, 4'(i+2), 32'h108 + 32'(4*i));
      else       drive_req(1'b0, 4'd0, 32'h0);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0 || mreq_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hit_b2b_end got %0b/%0b want 0/0", rsp_valid, mreq_valid);
    end
  endtask

  task automatic test_nuke_hit();
    drive_req(1'b1, 4'd7, 32'h104);
    nuke_valid = 1'b1;
    tick();
    nuke_valid = 1'b0;
    drive_req(1'b1, 4'd8, 32'h108);
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0) begin
      tests_failed++; $display("FAIL nuke_drop got %0b/%h want 0/00000000", rsp_valid, rsp_instr);
    end
    tick();
    drive_req(1'b0, 4'd0, 32'h0);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h22222222 || rsp_id !== 4'd8 || rsp_pc !== 32'h108) begin
      tests_failed++; $display("FAIL nuke_after got %0b/%h/%h/%h want 1/00000108/22222222/8", rsp_valid, rsp_pc, rsp_instr, rsp_id);
    end
    tick();
  endtask

  task automatic test_stall_ready();
    int hs = 0;
    drive_req(1'b1, 4'd3, 32'h208);
    tick();
    drive_req(1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (mreq_valid !== 1'b1 || mreq_addr !== 32'h200) begin
        tests_failed++; $display("FAIL stall_hold[%0d] got %0b/%h want 1/00000200", i, mreq_valid, mreq_addr);
      end
      if (mreq_valid && mreq_ready) hs++;
      tick();
    end
    mreq_ready = 1'b1;
    if (mreq_valid && mreq_ready) hs++;
    tick();
    mreq_ready = 1'b1;
    if (mreq_valid && mreq_ready) hs++;
    tick();
    mreq_ready = 1'b0;
    tests_run++;
    if (hs !== 1) begin
      tests_failed++; $display("FAIL stall_handshakes got %0d want 1", hs);
    end
    mrsp_valid = 1'b1;
    mrsp_data  = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    tick();
    mrsp_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_pc !== 32'h208 || rsp_instr !== 32'hC2C2C2C2 || rsp_id !== 4'd3) begin
      tests_failed++; $display("FAIL stall_fill got %0b/%h/%h/%h want 1/00000208/c2c2c2c2/3", rsp_valid, rsp_pc, rsp_instr, rsp_id);
    end
    tick();
  endtask

  task automatic test_flush_fill();
    drive_req(1'b1, 4'd5, 32'h300);
    tick();
    drive_req(1'b0, 4'd0, 32'h0);
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    br_valid   = 1'b1;
    tick();
    br_valid   = 1'b0;
    mrsp_valid = 1'b1;
    mrsp_data  = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
    tick();
    mrsp_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_pc !== 32'h0) begin
      tests_failed++; $display("FAIL flush_suppress got %0b/%h want 0/00000000", rsp_valid, rsp_pc);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_suppress2 got %0b want 0", rsp_valid);
    end
    drive_req(1'b1, 4'd6, 32'h304);
    tick();
    drive_req(1'b0, 4'd0, 32'h0);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h44440001 || rsp_pc !== 32'h304 || rsp_id !== 4'd6 || mreq_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_then_hit got %0b/%h/%h/%h mreq %0b want 1/00000304/44440001/6 mreq 0",
        rsp_valid, rsp_pc, rsp_instr, rsp_id, mreq_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    drive_req(1'b1, 4'd9, 32'h400);
    tick();
    drive_req(1'b0, 4'd0, 32'h0);
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mrsp_valid = 1'b1;
    mrsp_data  = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
    tick();
    mrsp_valid = 1'b0;
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_pc, rsp_instr, mreq_valid, mreq_addr} !== '0) begin
      tests_failed++; $display("FAIL rst_stray got %0b/%h/%h/%h mreq %0b/%h want all 0",
        rsp_valid, rsp_id, rsp_pc, rsp_instr, mreq_valid, mreq_addr);
    end
    drive_req(1'b1, 4'd10, 32'h404);
    tick();
    drive_req(1'b0, 4'd0, 32'h0);
    tests_run++;
    if (rsp_valid !== 1'b0 || mreq_valid !== 1'b1 || mreq_addr !== 32'h400) begin
      tests_failed++; $display("FAIL rst_then_miss got rsp %0b mreq %0b/%h want rsp 0 mreq 1/00000400", rsp_valid, mreq_valid, mreq_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_nuke_hit();
    test_stall_ready();
    test_flush_fill();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fe_fb.md
FE_FB -- requirements
Module: fe_fb

Interface
REQ-001 Parameter: LINE_BYTES, 16, bytes per line buffer entry; power of two, >= 8.
REQ-002 Parameter: PADDR_W, 32, physical address width (matches t_paddr).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fe_fb_req_nnn  input  t_fe_fb_req  fetch request from fetch control: valid, id, addr[PADDR_W-1:0].
REQ-006 fb_fe_rsp_nnn  output  t_fb_fe_rsp  response to fetch control: valid, id, pc, instr (t_rv_instr, 32 bits).
REQ-007 br_mispred_ex0  input  t_br_mispred_pkt  flush source; only .valid used.
REQ-008 nuke_rb1  input  t_nuke_pkt  flush source; only .valid used.
REQ-009 fb_mem_req_valid  output  1  line fill request to memory.
REQ-010 fb_mem_req_addr  output  PADDR_W  line-aligned fill address (low log2(LINE_BYTES) bits zero).
REQ-011 mem_fb_req_ready  input  1  memory accepts request when valid & ready.
REQ-012 mem_fb_rsp_valid  input  1  fill data valid, one cycle pulse.
REQ-013 mem_fb_rsp_data  input  8*LINE_BYTES  fill data; byte 0 at bits [7:0].

Function
REQ-014 Block SHALL hold one line buffer: tag (addr above line offset), valid bit, data.
REQ-015 FSM states SHALL be FB_IDLE, FB_MEM_REQ, FB_MEM_WAIT, FB_FILL_RSP.
REQ-016 Flush SHALL be br_mispred_ex0.valid | nuke_rb1.valid in a cycle.
REQ-017 In FB_IDLE, a request with line valid and tag match (hit) SHALL produce fb_fe_rsp_nnn.valid exactly 1 cycle later; state stays FB_IDLE.
REQ-018 Hit response: instr = 32-bit word at addr[log2(LINE_BYTES)-1:2] within line, pc = request addr, id = request id.
REQ-019 In FB_IDLE, a miss SHALL latch addr/id, go to FB_MEM_REQ next cycle.
REQ-020 FB_MEM_REQ: fb_mem_req_valid=1, addr = latched line address; held stable until mem_fb_req_ready; on handshake go FB_MEM_WAIT.
REQ-021 FB_MEM_WAIT: on mem_fb_rsp_valid write data, set tag and valid, go FB_FILL_RSP.
REQ-022 FB_FILL_RSP: drive response from new line for latched addr/id (valid=1 one cycle) unless dropped (REQ-025); next state FB_IDLE.
REQ-023 Only one request outstanding; fe_fb_req_nnn.valid SHALL be ignored outside FB_IDLE and the hit-response cycle and flagged by assertion.
REQ-024 A request arriving in the same cycle as a hit response SHALL be accepted (back-to-back hits, 1 response per cycle).
REQ-025 Flush: sets drop flag for the outstanding request; pending or next-cycle response SHALL have valid=0; request arriving in the flush cycle SHALL be discarded.
REQ-026 Flush in FB_MEM_REQ/FB_MEM_WAIT SHALL NOT abort memory transaction; fill completes and line is written; response suppressed; return to FB_IDLE.
REQ-027 Drop flag SHALL clear on return to FB_IDLE; requests after flush cycle treated normally.
REQ-028 mem_fb_rsp_valid outside FB_MEM_WAIT SHALL be ignored and flagged by assertion.
REQ-029 fb_fe_rsp_nnn fields other than valid SHALL be '0 when valid=0.

Reset
REQ-030 On reset: state FB_IDLE, line valid=0, drop flag=0, fb_fe_rsp_nnn='0, fb_mem_req_valid=0, fb_mem_req_addr=0.
REQ-031 Reset mid-fill SHALL abandon the transaction; a later mem_fb_rsp_valid is ignored (REQ-028).
REQ-032 Tag and data arrays need no reset.

Verification
REQ-033 Reset, req addr 0x100 id 0 -> fb_mem_req_valid with addr 0x100; ready same cycle; rsp data words {W0..W3} 3 cycles later -> next cycle rsp valid, pc 0x100, instr W0.
REQ-034 After REQ-033, reqs 0x104, 0x108, 0x10C on consecutive cycles -> rsps W1, W2, W3 on consecutive cycles, no memory request.
REQ-035 Req 0x200 miss with mem_fb_req_ready low 5 cycles -> fb_mem_req_valid/addr 0x200 stable all 5 cycles, one handshake only.
REQ-036 Req 0x300 miss, br_mispred_ex0.valid during FB_MEM_WAIT -> fill completes, no fb_fe_rsp valid; following req 0x304 hits with 1-cycle latency.
REQ-037 nuke_rb1.valid same cycle as hit request 0x104 -> no response next cycle; req next cycle responds normally.
REQ-038 Reset asserted in FB_MEM_WAIT, then stray mem_fb_rsp_valid -> outputs stay '0, line valid=0, next req to same line misses.
